// File: rtl/blake2_block_feeder_if.sv
// rtl/blake2_block_feeder_if.sv - byte-stream input and blake2_core command bundle for the block feeder
// master is the feeder side; slave is the producer/core environment side.
interface blake2_block_feeder_if #(
  parameter int LEN_W = 64
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             core_init;
  logic             core_next;
  logic             core_final_block;
  logic [1023:0]    core_block;
  logic [LEN_W-1:0] core_data_length;
  logic             core_ready;
  logic             core_digest_valid;
  logic             msg_done;

  modport master (
    input  in_data, in_valid, in_last, core_ready, core_digest_valid,
    output in_ready, core_init, core_next, core_final_block, core_block,
           core_data_length, msg_done
  );

  modport slave (
    output in_data, in_valid, in_last, core_ready, core_digest_valid,
    input  in_ready, core_init, core_next, core_final_block, core_block,
           core_data_length, msg_done
  );
endinterface

// File: rtl/blake2_block_feeder.sv
// rtl/blake2_block_feeder.sv - packs a byte stream into 1024-bit big-endian blocks for blake2_core
// Drives init/next/final_block pulses, tracks data_length and waits for the final digest.
module blake2_block_feeder #(
  parameter int LEN_W = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  blake2_block_feeder_if.master bus
);

  localparam logic [1:0] S_FILL   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_BUSY   = 2'd2;
  localparam logic [1:0] S_DIGEST = 2'd3;

  logic [1:0]       r_state;
  logic [6:0]       r_byte_ptr;
  logic [LEN_W-1:0] r_total_len;
  logic [LEN_W-1:0] r_data_length;
  logic [1023:0]    r_block;
  logic             r_first_blk;
  logic             r_final_lat;
  logic             r_busy_first;
  logic             r_in_ready;
  logic             r_init;
  logic             r_next;
  logic             r_final;
  logic             r_msg_done;

  logic [9:0]       w_slot_msb;
  logic [LEN_W-1:0] w_len_inc;

  assign w_slot_msb = 10'd1023 - {r_byte_ptr, 3'b000};
  assign w_len_inc  = r_total_len + {{(LEN_W-1){1'b0}}, 1'b1};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= S_FILL;
      r_byte_ptr    <= 7'd0;
      r_total_len   <= '0;
      r_data_length <= '0;
      r_block       <= '0;
      r_first_blk   <= 1'b1;
      r_final_lat   <= 1'b0;
      r_busy_first  <= 1'b0;
      r_in_ready    <= 1'b1;
      r_init        <= 1'b0;
      r_next        <= 1'b0;
      r_final       <= 1'b0;
      r_msg_done    <= 1'b0;
    end else begin
      r_init     <= 1'b0;
      r_next     <= 1'b0;
      r_final    <= 1'b0;
      r_msg_done <= 1'b0;
      case (r_state)
        S_FILL: begin
          if (bus.in_valid) begin
            r_block[w_slot_msb -: 8] <= bus.in_data;
            r_byte_ptr               <= r_byte_ptr + 7'd1;
            r_total_len              <= w_len_inc;
            // A full block or the last byte closes the block; a 128th last byte makes it final.
            if (r_byte_ptr == 7'd127 || bus.in_last) begin
              r_state       <= S_ISSUE;
              r_final_lat   <= bus.in_last;
              r_data_length <= w_len_inc;
              r_in_ready    <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          if (bus.core_ready) begin
            r_init       <= r_first_blk;
            r_next       <= ~r_first_blk;
            r_final      <= r_final_lat;
            r_first_blk  <= 1'b0;
            r_busy_first <= 1'b1;
            r_state      <= r_final_lat ? S_DIGEST : S_BUSY;
          end
        end
        S_BUSY: begin
          // core_ready may still show the pre-command idle level during the pulse cycle.
          if (r_busy_first) begin
            r_busy_first <= 1'b0;
          end else if (bus.core_ready) begin
            r_block    <= '0;
            r_byte_ptr <= 7'd0;
            r_in_ready <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_DIGEST: begin
          if (bus.core_digest_valid) begin
            r_msg_done    <= 1'b1;
            r_block       <= '0;
            r_byte_ptr    <= 7'd0;
            r_total_len   <= '0;
            r_data_length <= '0;
            r_first_blk   <= 1'b1;
            r_in_ready    <= 1'b1;
            r_state       <= S_FILL;
          end
        end
        default: begin
          r_state    <= S_FILL;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.core_init        = r_init;
  assign bus.core_next        = r_next;
  assign bus.core_final_block = r_final;
  assign bus.core_block       = r_block;
  assign bus.core_data_length = r_data_length;
  assign bus.msg_done         = r_msg_done;

endmodule

// File: tb/tb_blake2_block_feeder.sv
// tb/tb_blake2_block_feeder.sv - self-checking bench for blake2_block_feeder
// Table-driven messages, hand-written corner sequences and random messages against a block-list model.
`timescale 1ns/1ps
module tb_blake2_block_feeder;
  localparam int LEN_W = 64;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    bit               init;
    bit               nxt;
    bit               fin;
    longint unsigned  len;
    logic [1023:0]    blk;
  } cmd_t;
  typedef struct {
    int               len;
    int               base;
    int               exp_cmds;
    longint unsigned  exp_last_len;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  cmd_t got[$];
  int   done_q[$];
  bit   hold_ready;
  bit   spurious;
  int   lat_min;
  int   lat_max;

  blake2_block_feeder_if #(.LEN_W(LEN_W)) bus ();

  blake2_block_feeder #(.LEN_W(LEN_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Core stand-in: goes busy for a random latency after each command, then reports
  // idle again, with a one-cycle digest_valid when the command was the final block.
  initial begin
    int busy;
    bit pend;
    busy = 0;
    pend = 0;
    bus.core_ready        = 1'b1;
    bus.core_digest_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.core_digest_valid = 1'b0;
      if (rst) begin
        busy = 0;
        pend = 0;
      end else if (bus.core_init || bus.core_next) begin
        busy = $urandom_range(lat_max, lat_min);
        pend = bus.core_final_block;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0 && pend) begin
          bus.core_digest_valid = 1'b1;
          pend = 0;
        end
      end else if (spurious) begin
        bus.core_digest_valid = 1'b1;
        spurious = 0;
      end
      bus.core_ready = (busy == 0) && !hold_ready;
    end
  end

  // Output monitor: records every command, checks pulse shape and zeroing on refill/done.
  initial begin
    bit prev_pulse;
    bit prev_rdy;
    prev_pulse = 0;
    prev_rdy   = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.core_init || bus.core_next) begin
          got.push_back('{bus.core_init, bus.core_next, bus.core_final_block,
                          bus.core_data_length, bus.core_block});
          chk("pulse_one_cycle", prev_pulse, 1'b0);
          chk("init_next_exclusive", bus.core_init & bus.core_next, 1'b0);
        end else begin
          chk("final_without_pulse", bus.core_final_block, 1'b0);
        end
        if (bus.msg_done) begin
          done_q.push_back(cyc);
          chk("done_len_zero", bus.core_data_length, '0);
          chk("done_block_zero", bus.core_block, '0);
        end
        if (bus.in_ready && !prev_rdy)
          chk("refill_block_zero", bus.core_block, '0);
        prev_pulse = bus.core_init | bus.core_next;
        prev_rdy   = bus.in_ready;
      end else begin
        prev_pulse = 0;
        prev_rdy   = 1;
      end
    end
  end

  task automatic send(input byte_q_t msg, input int gap_pct, input bit no_last,
                      input bit keep_valid, output int first_acc);
    int i;
    int guard;
    int c;
    logic rdy;
    i = 0;
    guard = 0;
    first_acc = -1;
    while (i < msg.size()) begin
      @(negedge clk);
      c = cyc;
      bus.in_valid = ($urandom_range(99, 0) >= gap_pct);
      bus.in_data  = msg[i];
      bus.in_last  = !no_last && (i == msg.size() - 1);
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) begin
        if (first_acc < 0) first_acc = c;
        i++;
      end
      guard++;
      if (guard > 20000) begin
        errors++;
        $display("FAIL send_timeout got=%0d bytes exp=%0d bytes", i, msg.size());
        break;
      end
    end
    @(negedge clk);
    if (!keep_valid) begin
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_q.size() < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (done_q.size() < target) begin
      errors++;
      $display("FAIL msg_done_timeout got=%0d exp=%0d", done_q.size(), target);
    end
  endtask

  function automatic logic [1023:0] exp_block(input byte_q_t m, input int b);
    logic [1023:0] v;
    logic [7:0]    bv;
    v = '0;
    for (int k = 0; k < 128; k++) begin
      bv = (b * 128 + k < m.size()) ? m[b * 128 + k] : 8'h00;
      v  = {v[1015:0], bv};
    end
    return v;
  endfunction

  // Reference: a message of n bytes becomes ceil(n/128) blocks; block b carries bytes
  // b*128.. big-endian, init on the first, next afterwards, final on the last.
  task automatic check_msg(input string tag, input byte_q_t m);
    int nb;
    longint unsigned el;
    nb = (m.size() + 127) / 128;
    chk({tag, "_cmd_count"}, got.size(), nb);
    for (int b = 0; b < nb && b < got.size(); b++) begin
      el = ((b + 1) * 128 < m.size()) ? (b + 1) * 128 : m.size();
      chk($sformatf("%s_init%0d", tag, b), got[b].init, b == 0);
      chk($sformatf("%s_next%0d", tag, b), got[b].nxt, b != 0);
      chk($sformatf("%s_final%0d", tag, b), got[b].fin, b == nb - 1);
      chk($sformatf("%s_len%0d", tag, b), got[b].len, el);
      chk($sformatf("%s_block%0d", tag, b), got[b].blk, exp_block(m, b));
    end
    got.delete();
  endtask

  function automatic byte_q_t str_msg(input string s);
    byte_q_t m;
    for (int i = 0; i < s.len(); i++) m.push_back(s[i]);
    return m;
  endfunction

  initial begin
    vec_t    vecs[7];
    byte_q_t m;
    byte_q_t m2;
    int      acc;
    int      acc2;
    int      base;

    vecs[0] = '{3,   'h61, 1, 64'd3};
    vecs[1] = '{128, 'h00, 1, 64'd128};
    vecs[2] = '{129, 'h00, 2, 64'd129};
    vecs[3] = '{1,   'hA5, 1, 64'd1};
    vecs[4] = '{127, 'h10, 1, 64'd127};
    vecs[5] = '{256, 'h03, 2, 64'd256};
    vecs[6] = '{257, 'h80, 3, 64'd257};

    checks = 0;
    errors = 0;
    hold_ready = 0;
    spurious = 0;
    lat_min = 2;
    lat_max = 4;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_init", bus.core_init, 1'b0);
    chk("rst_next", bus.core_next, 1'b0);
    chk("rst_final", bus.core_final_block, 1'b0);
    chk("rst_done", bus.msg_done, 1'b0);
    chk("rst_block", bus.core_block, '0);
    chk("rst_len", bus.core_data_length, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    spurious = 1;
    repeat (4) @(negedge clk);
    chk("spurious_digest_ignored", done_q.size(), 0);

    foreach (vecs[v]) begin
      m.delete();
      for (int i = 0; i < vecs[v].len; i++) m.push_back(8'(vecs[v].base + i));
      base = done_q.size();
      send(m, 0, 0, 0, acc);
      chk($sformatf("vec%0d_no_early_pulse", v), got.size(), vecs[v].exp_cmds - 1);
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_latency", v), got.size(), vecs[v].exp_cmds);
      wait_done(base + 1);
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_done_once", v), done_q.size(), base + 1);
      if (got.size() > 0) begin
        chk($sformatf("vec%0d_last_len", v), got[got.size() - 1].len, vecs[v].exp_last_len);
        chk($sformatf("vec%0d_last_final", v), got[got.size() - 1].fin, 1'b1);
      end
      check_msg($sformatf("vec%0d", v), m);
    end

    // Backpressure: core held busy for 20 cycles after the last byte.
    m = str_msg("flamingo");
    base = done_q.size();
    hold_ready = 1;
    repeat (2) @(negedge clk);
    send(m, 0, 0, 0, acc);
    for (int i = 0; i < 20; i++) begin
      chk("bp_in_ready_low", bus.in_ready, 1'b0);
      chk("bp_block_stable", bus.core_block, exp_block(m, 0));
      chk("bp_len_stable", bus.core_data_length, 64'd8);
      chk("bp_no_pulse", got.size(), 0);
      @(negedge clk);
    end
    hold_ready = 0;
    @(negedge clk);
    chk("bp_no_pulse_before_sample", got.size(), 0);
    @(negedge clk);
    chk("bp_pulse_on_sample", got.size(), 1);
    wait_done(base + 1);
    check_msg("bp", m);

    // Reset after 50 bytes of an unterminated message.
    m.delete();
    for (int i = 0; i < 50; i++) m.push_back(8'($urandom));
    send(m, 0, 1, 0, acc);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_block", bus.core_block, '0);
    chk("mid_rst_len", bus.core_data_length, '0);
    chk("mid_rst_pulses", {bus.core_init, bus.core_next, bus.core_final_block, bus.msg_done}, 4'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got.delete();
    done_q.delete();
    m = str_msg("cranberry");
    send(m, 0, 0, 0, acc);
    wait_done(1);
    check_msg("cranberry", m);

    // Back-to-back messages with in_valid held high throughout.
    m  = str_msg("abc");
    m2 = str_msg("abc");
    base = done_q.size();
    send(m, 0, 0, 1, acc);
    send(m2, 0, 0, 0, acc2);
    wait_done(base + 2);
    checks++;
    if (done_q.size() > base && acc2 < done_q[base]) begin
      errors++;
      $display("FAIL b2b_accept_before_done got=%0d exp>=%0d", acc2, done_q[base]);
    end
    chk("b2b_cmd_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("b2b_second_init", got[1].init, 1'b1);
      chk("b2b_second_len", got[1].len, 64'd3);
      chk("b2b_second_block", got[1].blk, exp_block(m2, 0));
    end
    got.delete();

    // Random messages with input gaps and varying core latency.
    lat_min = 2;
    lat_max = 8;
    for (int r = 0; r < 12; r++) begin
      m.delete();
      for (int i = 0; i < int'($urandom_range(300, 1)); i++) m.push_back(8'($urandom));
      base = done_q.size();
      send(m, 30, 0, 0, acc);
      wait_done(base + 1);
      check_msg($sformatf("rnd%0d", r), m);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_block_feeder.md
# blake2_block_feeder

Upstream packer for `blake2_core`. It accepts a message as a byte stream with a valid/ready handshake and assembles the bytes into 1024-bit big-endian blocks. It drives the core's `init`/`next`/`final_block` command pulses and keeps a running `data_length`. After the final block it waits for the core's `digest_valid`, then signals message completion and accepts the next message.

## Interface
- `LEN_W`, default 64: width of the byte counter and of `core_data_length`. Must be 64 to match `blake2_core`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in 8: message byte.
- `in_valid` in 1: `in_data` is valid.
- `in_last` in 1: qualifies the byte as the final byte of the message. Messages are at least 1 byte.
- `in_ready` out 1: the block accepts a byte this cycle. A transfer occurs when `in_valid & in_ready`.
- `core_init` out 1: one-cycle pulse; first block of a message.
- `core_next` out 1: one-cycle pulse; each subsequent block.
- `core_final_block` out 1: high together with the `init`/`next` pulse of the last block of a message; low otherwise.
- `core_block` out 1024: assembled block. Byte k sits at `[1023-8k -: 8]`. Unused bytes are 0.
- `core_data_length` out LEN_W: cumulative message bytes up to and including the current block.
- `core_ready` in 1: core idle.
- `core_digest_valid` in 1: core digest valid.
- `msg_done` out 1: one-cycle pulse when the final digest is valid.

## Operation
- States:
  - FILL: `in_ready`=1.
  - ISSUE: waiting for `core_ready` to issue a command.
  - BUSY: a non-final block is being processed.
  - DIGEST: waiting for the final digest.
- Registers:
  - `byte_ptr`, 7 bits, 0..127.
  - `total_len`, LEN_W bits; increments on every accepted byte.
  - `first_blk` flag; set at reset and after `msg_done`.
  - `final_lat`.
- FILL: each accepted byte is written to slot `byte_ptr`, then `byte_ptr` increments and `total_len` increments.
  - If the accepted byte has `byte_ptr`==127 or `in_last`=1, go to ISSUE and latch `final_lat`=`in_last`.
  - A 128th byte with `in_last`=1 makes that full block the final block. No lookahead is needed.
- ISSUE: when `core_ready`=1, pulse `core_init` if `first_blk` is set, else pulse `core_next`.
  - `core_final_block`=`final_lat` and `core_data_length`=`total_len` are driven in the same cycle as the pulse.
  - On issue, clear `first_blk`.
  - If `final_lat`=1, go to DIGEST; otherwise go to BUSY.
- BUSY: ignore `core_ready` in the first cycle after the pulse. Thereafter, on `core_ready`=1, zero `core_block`, set `byte_ptr`=0 and return to FILL.
- DIGEST: on `core_digest_valid`=1:
  - pulse `msg_done`;
  - zero `core_block`, `byte_ptr`, `total_len` and `core_data_length`;
  - set `first_blk`;
  - go to FILL.
- `core_block` and `core_data_length` stay stable from entry to ISSUE until the exit from BUSY or DIGEST.
- Bytes beyond `in_last` in the same message are not possible: `in_ready`=0 until `msg_done`.
- `total_len` wraps modulo 2^LEN_W. No overflow flag.

## Timing
- Reset values:
  - state=FILL;
  - `core_init`=`core_next`=`core_final_block`=`msg_done`=0;
  - `core_block`=0, `core_data_length`=0, `total_len`=0, `byte_ptr`=0;
  - `first_blk`=1;
  - `in_ready`=1 once reset deasserts. No transfer is captured while `reset`=1.
- Throughput: 1 byte/cycle in FILL.
- Latency from the last byte accepted to the command pulse: 1 cycle if `core_ready`=1, else 1 cycle after `core_ready` rises.
- All outputs are registered. Command pulses last exactly one cycle.
- `msg_done` is asserted the cycle after `core_digest_valid` is sampled high.
- Reset mid-operation: abort immediately and return to the reset values. The core is reset from the same source by the integrator.
- A `core_digest_valid` outside DIGEST is ignored.

## Test plan
- "abc" (`in_last` on 0x63) -> one `core_init`, `core_final_block`=1, `core_data_length`=3, `core_block`=0x616263 followed by zeros. With DIGEST_LENGTH=11 the core digest is 0xac7b0972cbd915185ac929, and `msg_done` pulses once.
- 128 bytes 0x00..0x7F, `in_last` on byte 128 -> a single `core_init` with `core_final_block`=1, length 128. No `core_next`.
- 129 bytes 0x00..0x80 ->
  - `core_init` with final=0, length 128;
  - then `core_next` with final=1, length 129, `core_block[1023:1016]`=0x80, rest zero;
  - `in_ready`=0 between the blocks until `core_ready` returns.
- Backpressure: hold `core_ready`=0 for 20 cycles after "flamingo" -> `in_ready`=0, no pulse, `core_block` stable. The pulse occurs in the cycle `core_ready`=1 is sampled; length 8, digest 0x8799874c79a16d50742428.
- Reset asserted after 50 bytes, then "cranberry" -> all outputs return to 0, then `core_init` with length 9, digest 0x3ca6d159ecf58601c23db7.
- Back-to-back "abc" then "abc" with `in_valid` held high -> no second-message byte accepted before `msg_done`. The second message uses `core_init` and length 3.
